// File: rtl/fsm1_scheduler.sv
// Round-robin scheduler that serialises one requester's 3-bit frame onto a shared detector.
// Optional macro FSM1_SCHED_CLR_EN inserts a one-cycle detector clear (CLR) before each frame.
module fsm1_scheduler #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NREQ-1:0]   Req,
    input  logic [3*NREQ-1:0] Data,
    output logic [NREQ-1:0]   Ack,
    output logic              Result,
    output logic [IDW-1:0]    Gnt_Id,
    output logic              Busy,
    output logic              Det_Din,
    input  logic              Det_Dout,
    output logic              Det_Rst_n,
    output logic [2:0]        dbg_state
);

    // Handshake: a requester raises Req[i] with a stable frame on Data and keeps Req[i]
    // high until Ack[i] pulses for one cycle; the frame is latched at grant, so later
    // changes to Req or Data never affect the frame in flight.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_BIT0 = 3'd2,
        S_BIT1 = 3'd3,
        S_BIT2 = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_d;
    logic [2:0]      frm, frm_d;
    logic            cool;
    logic            found, grant;
    logic [IDW-1:0]  gnt_idx;
    logic [2:0]      gnt_frm;
    logic [NREQ-1:0] ack_d;
    logic            result_d, busy_d, din_d;
    logic [IDW-1:0]  gnt_d;

    assign dbg_state = state;

    // First requester at or above ptr, else the lowest one (wrap-around search).
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt_frm = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && Req[j] && (IDW'(j) >= ptr)) begin
                found   = 1'b1;
                gnt_idx = IDW'(j);
                gnt_frm = Data[3*j +: 3];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && Req[j]) begin
                found   = 1'b1;
                gnt_idx = IDW'(j);
                gnt_frm = Data[3*j +: 3];
            end
        end
    end

    // cool blocks granting in the IDLE cycle right after RESP.
    assign grant = (state == S_IDLE) && !cool && found;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            ptr     <= '0;
            frm     <= '0;
            cool    <= 1'b0;
            Ack     <= '0;
            Result  <= 1'b0;
            Gnt_Id  <= '0;
            Busy    <= 1'b0;
            Det_Din <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_d;
            frm     <= frm_d;
            cool    <= (state == S_RESP);
            Ack     <= ack_d;
            Result  <= result_d;
            Gnt_Id  <= gnt_d;
            Busy    <= busy_d;
            Det_Din <= din_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant) begin
`ifdef FSM1_SCHED_CLR_EN
                    state_nxt = S_CLR;
`else
                    state_nxt = S_BIT0;
`endif
                end
            end
            S_CLR:   state_nxt = S_BIT0;
            S_BIT0:  state_nxt = S_BIT1;
            S_BIT1:  state_nxt = S_BIT2;
            S_BIT2:  state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; Det_Din carries the bit of the upcoming state.
    always_comb begin
        ack_d    = '0;
        result_d = Result;
        gnt_d    = Gnt_Id;
        busy_d   = Busy;
        din_d    = 1'b0;
        frm_d    = frm;
        ptr_d    = ptr;
        case (state)
            S_IDLE: begin
                if (grant) begin
                    frm_d  = gnt_frm;
                    gnt_d  = gnt_idx;
                    busy_d = 1'b1;
                    ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef FSM1_SCHED_CLR_EN
                    din_d  = 1'b0;
`else
                    din_d  = gnt_frm[0];
`endif
                end
            end
            S_CLR:  din_d = frm[0];
            S_BIT0: din_d = frm[1];
            S_BIT1: din_d = frm[2];
            S_BIT2: begin
                result_d = Det_Dout;
                ack_d    = {{(NREQ-1){1'b0}}, 1'b1} << Gnt_Id;
            end
            S_RESP: busy_d = 1'b0;
            default: ;
        endcase
    end

`ifdef FSM1_SCHED_CLR_EN
    logic det_rst_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            det_rst_q <= 1'b1;
        end else begin
            det_rst_q <= !grant;
        end
    end

    assign Det_Rst_n = det_rst_q;
`else
    assign Det_Rst_n = Reset;
`endif

endmodule

// File: tb/tb_fsm1_scheduler.sv
// Self-checking bench for fsm1_scheduler: table of single-frame vectors plus
// hand-written sequences for round-robin order, mid-frame Req drop and mid-frame reset.
module tb_fsm1_scheduler;

`ifdef FSM1_SCHED_CLR_EN
    localparam int   LAT     = 5;
    localparam int   RST_LOW = 1;
    localparam logic RST_DUR = 1'b1;
`else
    localparam int   LAT     = 4;
    localparam int   RST_LOW = 0;
    localparam logic RST_DUR = 1'b0;
`endif
    localparam int PERIOD = LAT + 2;

    logic        Clock;
    logic        Reset;
    logic [3:0]  Req;
    logic [11:0] Data;
    logic [3:0]  Ack;
    logic        Result;
    logic [1:0]  Gnt_Id;
    logic        Busy;
    logic        Det_Din;
    logic        Det_Dout;
    logic        Det_Rst_n;
    logic [2:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [6:0] exp_q[$];

    fsm1_scheduler #(.NREQ(4), .IDW(2)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Req       (Req),
        .Data      (Data),
        .Ack       (Ack),
        .Result    (Result),
        .Gnt_Id    (Gnt_Id),
        .Busy      (Busy),
        .Det_Din   (Det_Din),
        .Det_Dout  (Det_Dout),
        .Det_Rst_n (Det_Rst_n),
        .dbg_state (dbg_state)
    );

    // Clock / reset block.
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Detector model: Dout is high when the bit two cycles back and the current bit are both 1.
    logic [1:0] det_sh;
    always @(posedge Clock or negedge Det_Rst_n) begin
        if (!Det_Rst_n) det_sh <= 2'b00;
        else            det_sh <= {det_sh[0], Det_Din};
    end
    assign Det_Dout = det_sh[1] & Det_Din;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Driver: presents one request and follows it to its Ack (bounded), then releases Req.
    task automatic run_frame(input logic [3:0] req, input logic [11:0] data,
                             input int mod_cyc, input logic [11:0] mod_data,
                             output logic [3:0] ack, output logic res, output logic [1:0] gnt,
                             output logic [2:0] din, output int lat, output int rst_low,
                             output int busy_cnt);
        logic hist [32];
        Req = req;
        Data = data;
        lat = -1;
        rst_low = 0;
        busy_cnt = 0;
        ack = '0;
        res = 1'b0;
        gnt = '0;
        din = '0;
        for (int c = 1; c < 32; c++) begin
            tick();
            if (c == mod_cyc) begin
                Req = '0;
                Data = mod_data;
            end
            hist[c] = Det_Din;
            if (!Det_Rst_n) rst_low++;
            if (Busy) busy_cnt++;
            if (Ack != 4'b0000) begin
                ack = Ack;
                res = Result;
                gnt = Gnt_Id;
                lat = c;
                break;
            end
        end
        if (lat >= 3) din = {hist[lat-1], hist[lat-2], hist[lat-3]};
        Req = '0;
        tick();
        tick();
    endtask

    task automatic check_frame(input string name, input logic [3:0] ack, input logic res,
                               input logic [1:0] gnt, input logic [2:0] din, input int lat,
                               input int rst_low, input int busy_cnt, input logic [3:0] e_ack,
                               input logic e_res, input logic [1:0] e_gnt, input logic [2:0] e_din);
        check({name, " ack"}, 32'(ack), 32'(e_ack));
        check({name, " result"}, 32'(res), 32'(e_res));
        check({name, " gnt_id"}, 32'(gnt), 32'(e_gnt));
        check({name, " din_seq"}, 32'(din), 32'(e_din));
        check({name, " latency"}, lat, LAT);
        check({name, " det_rst_low"}, rst_low, RST_LOW);
        check({name, " busy_cycles"}, busy_cnt, LAT);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [11:0] data;
        logic [3:0]  exp_ack;
        logic        exp_res;
        logic [1:0]  exp_gnt;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [3:0]  ack;
        logic        res;
        logic [1:0]  gnt;
        logic [2:0]  din;
        logic [11:0] sh;
        logic [6:0]  e;
        int lat, rst_low, busy_cnt, last, n_ack, n_extra;

        // Vectors start from ptr = 0 and chain: each grant moves ptr past the winner.
        vecs[0] = '{4'b0001, 12'h005, 4'b0001, 1'b1, 2'd0};
        vecs[1] = '{4'b0001, 12'h004, 4'b0001, 1'b0, 2'd0};
        vecs[2] = '{4'b0001, 12'h001, 4'b0001, 1'b0, 2'd0};
        vecs[3] = '{4'b0010, 12'h038, 4'b0010, 1'b1, 2'd1};
        vecs[4] = '{4'b1000, 12'hC00, 4'b1000, 1'b0, 2'd3};
        vecs[5] = '{4'b1001, 12'hA03, 4'b0001, 1'b0, 2'd0};
        vecs[6] = '{4'b1001, 12'hA03, 4'b1000, 1'b1, 2'd3};
        vecs[7] = '{4'b0110, 12'h1E0, 4'b0010, 1'b0, 2'd1};
        vecs[8] = '{4'b0110, 12'h1E0, 4'b0100, 1'b1, 2'd2};

        Reset = 1'b0;
        Req = '0;
        Data = '0;
        tick();
        tick();
        check("reset ack", 32'(Ack), 0);
        check("reset busy", 32'(Busy), 0);
        Reset = 1'b1;
        check("idle state", 32'(dbg_state), 0);
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("idle outputs c%0d", c),
                  32'({Ack, Result, Gnt_Id, Busy, Det_Din, Det_Rst_n}), 32'b0000_0_00_0_0_1);
        end

        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].req, vecs[i].data, -1, 12'h000,
                      ack, res, gnt, din, lat, rst_low, busy_cnt);
            sh = vecs[i].data >> (3 * vecs[i].exp_gnt);
            check_frame($sformatf("vec%0d", i), ack, res, gnt, din, lat, rst_low, busy_cnt,
                        vecs[i].exp_ack, vecs[i].exp_res, vecs[i].exp_gnt, sh[2:0]);
        end

        // All four requesting from reset: strict rotation 0,1,2,3,0 at full throughput.
        Reset = 1'b0;
        Req = 4'hF;
        Data = 12'h9DD;
        tick();
        tick();
        exp_q.push_back({4'b0001, 2'd0, 1'b1});
        exp_q.push_back({4'b0010, 2'd1, 1'b0});
        exp_q.push_back({4'b0100, 2'd2, 1'b1});
        exp_q.push_back({4'b1000, 2'd3, 1'b0});
        exp_q.push_back({4'b0001, 2'd0, 1'b1});
        Reset = 1'b1;
        last = 0;
        n_ack = 0;
        for (int c = 1; c < 60; c++) begin
            tick();
            if (Ack != 4'b0000) begin
                e = exp_q.pop_front();
                check($sformatf("rr%0d ack", n_ack), 32'(Ack), 32'(e[6:3]));
                check($sformatf("rr%0d gnt_id", n_ack), 32'(Gnt_Id), 32'(e[2:1]));
                check($sformatf("rr%0d result", n_ack), 32'(Result), 32'(e[0]));
                check($sformatf("rr%0d spacing", n_ack), c - last, (n_ack == 0) ? LAT : PERIOD);
                last = c;
                n_ack++;
                if (n_ack == 5) break;
            end
        end
        check("rr ack count", n_ack, 5);
        Req = '0;
        tick();
        tick();

        // Requester 2 drops Req and changes Data during BIT1; latched frame must finish.
        run_frame(4'b0100, 12'h140, LAT - 2, 12'h080, ack, res, gnt, din, lat, rst_low, busy_cnt);
        check_frame("drop", ack, res, gnt, din, lat, rst_low, busy_cnt,
                    4'b0100, 1'b1, 2'd2, 3'b101);
        n_extra = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (Ack != 4'b0000) n_extra++;
        end
        check("drop no regrant", n_extra, 0);

        // Reset in BIT1 of requester 1's frame; afterwards search restarts at requester 0.
        Req = 4'b0010;
        Data = 12'h038;
        for (int c = 1; c <= LAT - 2; c++) tick();
        check("pre-reset din", 32'(Det_Din), 1);
        check("pre-reset busy", 32'(Busy), 1);
        Reset = 1'b0;
        #1;
        check("mid reset ack", 32'(Ack), 0);
        check("mid reset result", 32'(Result), 0);
        check("mid reset gnt_id", 32'(Gnt_Id), 0);
        check("mid reset busy", 32'(Busy), 0);
        check("mid reset din", 32'(Det_Din), 0);
        check("mid reset det_rst_n", 32'(Det_Rst_n), 32'(RST_DUR));
        Req = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("held reset c%0d", c), 32'({Ack, Busy}), 0);
        end
        Reset = 1'b1;
        run_frame(4'b1001, 12'hA01, -1, 12'h000, ack, res, gnt, din, lat, rst_low, busy_cnt);
        check_frame("after reset", ack, res, gnt, din, lat, rst_low, busy_cnt,
                    4'b0001, 1'b0, 2'd0, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
